// File: rtl/idu_scoreboard_ctrl_pkg.sv
// Shared constants and types for the IDU scoreboard issue controller.
package idu_scoreboard_ctrl_pkg;

    localparam int GPR_NUM   = 32;
    localparam int CSR_NUM   = 8;
    localparam int CNT_W     = 2;
    localparam int INFL_W    = 4;
    localparam int GPR_IDX_W = 5;
    localparam int CSR_IDX_W = 3;

    typedef logic [CNT_W-1:0] sb_cnt_t;

    typedef struct packed {
        logic [GPR_IDX_W-1:0] rs1;
        logic [GPR_IDX_W-1:0] rs2;
        logic [GPR_IDX_W-1:0] rd;
        logic                 use_rs1;
        logic                 use_rs2;
        logic                 write_gpr;
        logic [CSR_IDX_W-1:0] csr_rs;
        logic [CSR_IDX_W-1:0] csr_rd;
        logic                 use_csr;
        logic                 write_csr;
    } issue_req_t;

endpackage

// File: rtl/idu_scoreboard_ctrl_if.sv
// Decode/EXU/WB handshake bundle seen by the scoreboard controller.
interface idu_scoreboard_ctrl_if;
    import idu_scoreboard_ctrl_pkg::*;

    logic                 IDU_valid;
    logic                 IDU_ready;
    logic [GPR_IDX_W-1:0] IDU_rs1;
    logic [GPR_IDX_W-1:0] IDU_rs2;
    logic                 IDU_use_rs1;
    logic                 IDU_use_rs2;
    logic [GPR_IDX_W-1:0] IDU_rd;
    logic                 IDU_write_gpr;
    logic [CSR_IDX_W-1:0] IDU_csr_rs;
    logic                 IDU_use_csr;
    logic [CSR_IDX_W-1:0] IDU_csr_rd;
    logic                 IDU_write_csr;
    logic                 EXU_valid;
    logic                 EXU_ready;
    logic                 flush;
    logic                 WB_valid;
    logic                 WB_sb_gpr;
    logic [GPR_IDX_W-1:0] WB_rd;
    logic                 WB_sb_csr;
    logic [CSR_IDX_W-1:0] WB_csr_rd;
    logic                 sb_idle;
    logic                 sb_stall;

    modport master (
        output IDU_valid, IDU_rs1, IDU_rs2, IDU_use_rs1, IDU_use_rs2, IDU_rd,
               IDU_write_gpr, IDU_csr_rs, IDU_use_csr, IDU_csr_rd, IDU_write_csr,
               EXU_ready, flush, WB_valid, WB_sb_gpr, WB_rd, WB_sb_csr, WB_csr_rd,
        input  IDU_ready, EXU_valid, sb_idle, sb_stall
    );

    modport slave (
        input  IDU_valid, IDU_rs1, IDU_rs2, IDU_use_rs1, IDU_use_rs2, IDU_rd,
               IDU_write_gpr, IDU_csr_rs, IDU_use_csr, IDU_csr_rd, IDU_write_csr,
               EXU_ready, flush, WB_valid, WB_sb_gpr, WB_rd, WB_sb_csr, WB_csr_rd,
        output IDU_ready, EXU_valid, sb_idle, sb_stall
    );

endinterface

// File: rtl/idu_sb_counter_bank.sv
// Bank of saturating-free pending counters with one allocate, one release and NRD read ports.
module idu_sb_counter_bank #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 2,
    parameter int NRD   = 3,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_alloc,
    input  logic [IDX_W-1:0]           i_alloc_idx,
    input  logic                       i_rel,
    input  logic [IDX_W-1:0]           i_rel_idx,
    input  logic [NRD-1:0][IDX_W-1:0]  i_rd_idx,
    output logic [NRD-1:0][WIDTH-1:0]  o_rd_cnt
);

    logic [DEPTH-1:0][WIDTH-1:0] r_cnt;
    logic [DEPTH-1:0]            w_inc;
    logic [DEPTH-1:0]            w_dec;
    logic [WIDTH-1:0]            w_rel_cnt;

    assign w_inc     = i_alloc ? (DEPTH'(1) << i_alloc_idx) : {DEPTH{1'b0}};
    assign w_dec     = i_rel   ? (DEPTH'(1) << i_rel_idx)   : {DEPTH{1'b0}};
    assign w_rel_cnt = r_cnt[i_rel_idx];

    // Per-entry update; allocate and release on the same entry cancel, zero never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + WIDTH'(1);
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != {WIDTH{1'b0}})) begin
                    r_cnt[i] <= r_cnt[i] - WIDTH'(1);
                end
            end
        end
    end

    // Read ports see only registered counts.
    always_comb begin
        o_rd_cnt = '0;
        for (int k = 0; k < NRD; k++) begin
            o_rd_cnt[k] = r_cnt[i_rd_idx[k]];
        end
    end

    idu_sb_counter_bank_chk #(.WIDTH(WIDTH)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .i_rel     (i_rel),
        .i_rel_cnt (w_rel_cnt)
    );

endmodule

// File: rtl/idu_sb_counter_bank_chk.sv
// Simulation checker: a release must never target a counter that is already zero.
module idu_sb_counter_bank_chk #(
    parameter int WIDTH = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             i_rel,
    input logic [WIDTH-1:0] i_rel_cnt
);

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        i_rel |-> (i_rel_cnt != {WIDTH{1'b0}}))
        else $error("scoreboard release of an idle counter");

endmodule

// File: rtl/idu_scoreboard_ctrl.sv
// Decode-to-EXU issue controller tracking pending GPR/CSR writes.
// Optional IDU_SB_PERF_EN adds stall/issue performance counters.
module idu_scoreboard_ctrl #(
    parameter int CNT_W   = idu_scoreboard_ctrl_pkg::CNT_W,
    parameter int CSR_NUM = idu_scoreboard_ctrl_pkg::CSR_NUM,
    parameter int INFL_W  = idu_scoreboard_ctrl_pkg::INFL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    idu_scoreboard_ctrl_if.slave  sb_if
`ifdef IDU_SB_PERF_EN
    ,
    output logic [31:0]           sb_stall_cnt,
    output logic [31:0]           sb_issue_cnt
`endif
);
    import idu_scoreboard_ctrl_pkg::*;

    issue_req_t                w_req;
    logic [2:0][CNT_W-1:0]     w_gcnt;
    logic [1:0][CNT_W-1:0]     w_ccnt;
    logic [INFL_W-1:0]         r_infl;
    logic                      w_alloc_gpr;
    logic                      w_alloc_any;
    logic                      w_rel_gpr;
    logic                      w_rel_csr;
    logic                      w_hazard;
    logic                      w_issue;
    logic                      w_infl_inc;
    logic                      w_infl_dec;

    assign w_req = '{rs1: sb_if.IDU_rs1, rs2: sb_if.IDU_rs2, rd: sb_if.IDU_rd,
                     use_rs1: sb_if.IDU_use_rs1, use_rs2: sb_if.IDU_use_rs2,
                     write_gpr: sb_if.IDU_write_gpr, csr_rs: sb_if.IDU_csr_rs,
                     csr_rd: sb_if.IDU_csr_rd, use_csr: sb_if.IDU_use_csr,
                     write_csr: sb_if.IDU_write_csr};

    assign w_alloc_gpr = w_req.write_gpr && (w_req.rd != 5'd0);
    assign w_alloc_any = w_alloc_gpr || w_req.write_csr;
    assign w_rel_gpr   = sb_if.WB_valid && sb_if.WB_sb_gpr && (sb_if.WB_rd != 5'd0);
    assign w_rel_csr   = sb_if.WB_valid && sb_if.WB_sb_csr;

    // x0 is never allocated, so its reads are masked rather than looked up.
    assign w_hazard =
        (w_req.use_rs1   && (w_req.rs1 != 5'd0) && (w_gcnt[0] != {CNT_W{1'b0}})) ||
        (w_req.use_rs2   && (w_req.rs2 != 5'd0) && (w_gcnt[1] != {CNT_W{1'b0}})) ||
        (w_req.use_csr   && (w_ccnt[0] != {CNT_W{1'b0}}))                       ||
        (w_alloc_gpr     && (w_gcnt[2] == {CNT_W{1'b1}}))                        ||
        (w_req.write_csr && (w_ccnt[1] == {CNT_W{1'b1}}))                        ||
        (w_alloc_any     && (r_infl == {INFL_W{1'b1}}));

    assign sb_if.EXU_valid = sb_if.IDU_valid && !sb_if.flush && !w_hazard;
    assign sb_if.IDU_ready = sb_if.flush || (sb_if.EXU_ready && !w_hazard);
    assign sb_if.sb_stall  = sb_if.IDU_valid && !sb_if.flush && w_hazard;
    assign sb_if.sb_idle   = (r_infl == {INFL_W{1'b0}});
    assign w_issue         = sb_if.EXU_valid && sb_if.EXU_ready;
    assign w_infl_inc      = w_issue && w_alloc_any;
    assign w_infl_dec      = w_rel_gpr || w_rel_csr;

    idu_sb_counter_bank #(.DEPTH(GPR_NUM), .WIDTH(CNT_W), .NRD(3)) u_gpr_bank (
        .clk         (clk),
        .rst         (rst),
        .i_alloc     (w_issue && w_alloc_gpr),
        .i_alloc_idx (w_req.rd),
        .i_rel       (w_rel_gpr),
        .i_rel_idx   (sb_if.WB_rd),
        .i_rd_idx    ({w_req.rd, w_req.rs2, w_req.rs1}),
        .o_rd_cnt    (w_gcnt)
    );

    idu_sb_counter_bank #(.DEPTH(CSR_NUM), .WIDTH(CNT_W), .NRD(2)) u_csr_bank (
        .clk         (clk),
        .rst         (rst),
        .i_alloc     (w_issue && w_req.write_csr),
        .i_alloc_idx (w_req.csr_rd),
        .i_rel       (w_rel_csr),
        .i_rel_idx   (sb_if.WB_csr_rd),
        .i_rd_idx    ({w_req.csr_rd, w_req.csr_rs}),
        .o_rd_cnt    (w_ccnt)
    );

    // One in-flight unit per allocating instruction, however many registers it writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_infl <= {INFL_W{1'b0}};
        end else if (w_infl_inc && !w_infl_dec) begin
            r_infl <= r_infl + INFL_W'(1);
        end else if (w_infl_dec && !w_infl_inc && (r_infl != {INFL_W{1'b0}})) begin
            r_infl <= r_infl - INFL_W'(1);
        end
    end

`ifdef IDU_SB_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_issue_cnt;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_issue_cnt <= 32'd0;
        end else begin
            if (sb_if.sb_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_issue)        r_issue_cnt <= r_issue_cnt + 32'd1;
        end
    end

    assign sb_stall_cnt = r_stall_cnt;
    assign sb_issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_idu_scoreboard_ctrl.sv
// Directed self-checking bench for idu_scoreboard_ctrl.
module tb_idu_scoreboard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    idu_scoreboard_ctrl_if sb_if ();

`ifdef IDU_SB_PERF_EN
    logic [31:0] stall_cnt_s;
    logic [31:0] issue_cnt_s;
    idu_scoreboard_ctrl dut (.clk(clk), .rst(rst), .sb_if(sb_if),
                             .sb_stall_cnt(stall_cnt_s), .sb_issue_cnt(issue_cnt_s));
`else
    idu_scoreboard_ctrl dut (.clk(clk), .rst(rst), .sb_if(sb_if));
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic ev, input logic ir, input logic st);
        check_eq({tag, "_exu_valid"}, 32'(sb_if.EXU_valid), 32'(ev));
        check_eq({tag, "_idu_ready"}, 32'(sb_if.IDU_ready), 32'(ir));
        check_eq({tag, "_stall"},     32'(sb_if.sb_stall),  32'(st));
    endtask

    task automatic chk_idle(input string tag, input logic exp);
        check_eq({tag, "_idle"}, 32'(sb_if.sb_idle), 32'(exp));
    endtask

    task automatic wb_off();
        sb_if.WB_valid  = 1'b0;
        sb_if.WB_sb_gpr = 1'b0;
        sb_if.WB_rd     = 5'd0;
        sb_if.WB_sb_csr = 1'b0;
        sb_if.WB_csr_rd = 3'd0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wg);
        sb_if.IDU_valid     = 1'b1;
        sb_if.IDU_rs1       = rs1;
        sb_if.IDU_use_rs1   = u1;
        sb_if.IDU_rs2       = rs2;
        sb_if.IDU_use_rs2   = u2;
        sb_if.IDU_rd        = rd;
        sb_if.IDU_write_gpr = wg;
        sb_if.IDU_csr_rs    = 3'd0;
        sb_if.IDU_use_csr   = 1'b0;
        sb_if.IDU_csr_rd    = 3'd0;
        sb_if.IDU_write_csr = 1'b0;
    endtask

    task automatic clr();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        sb_if.IDU_valid = 1'b0;
        sb_if.flush     = 1'b0;
        wb_off();
    endtask

    task automatic wb_gpr(input logic [4:0] rd);
        sb_if.WB_valid  = 1'b1;
        sb_if.WB_sb_gpr = 1'b1;
        sb_if.WB_rd     = rd;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        sb_if.EXU_ready = 1'b0;
        next_cyc();
        settle();
        chk_idle("rst", 1'b1);
        chk_o("rst", 1'b0, 1'b0, 1'b0);
        sb_if.EXU_ready = 1'b1;
        #1;
        check_eq("rst_ready", 32'(sb_if.IDU_ready), 32'd1);
        next_cyc();
        rst = 1'b0;

        // Back-to-back RAW on x5
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1); settle();
        chk_o("raw_issue", 1'b1, 1'b1, 1'b0); chk_idle("raw_issue", 1'b1);
        next_cyc(); instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1); settle();
        chk_o("raw_stall", 1'b0, 1'b0, 1'b1); chk_idle("raw_stall", 1'b0);
        next_cyc(); settle(); chk_o("raw_stall2", 1'b0, 1'b0, 1'b1);
        next_cyc(); wb_gpr(5'd5); settle(); chk_o("raw_wb_cycle", 1'b0, 1'b0, 1'b1);
        next_cyc(); wb_off(); settle(); chk_o("raw_unblock", 1'b1, 1'b1, 1'b0);
        next_cyc(); clr(); wb_gpr(5'd6); settle(); chk_idle("raw_rel6", 1'b0);
        next_cyc(); clr(); settle(); chk_idle("raw_done", 1'b1);

        // x0 destination and x0 sources
        next_cyc(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); settle();
        chk_o("x0_issue", 1'b1, 1'b1, 1'b0);
        next_cyc(); instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0); settle();
        chk_o("x0_read", 1'b1, 1'b1, 1'b0); chk_idle("x0_read", 1'b1);

        // EXU back-pressure: offered but not accepted, no allocation
        next_cyc(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1); sb_if.EXU_ready = 1'b0; settle();
        chk_o("bp", 1'b1, 1'b0, 1'b0);
        next_cyc(); clr(); sb_if.EXU_ready = 1'b1; settle(); chk_idle("bp_noalloc", 1'b1);

        // Saturation on x7
        for (int k = 0; k < 3; k++) begin
            next_cyc(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); settle();
            chk_o($sformatf("sat_issue%0d", k), 1'b1, 1'b1, 1'b0);
        end
        next_cyc(); settle(); chk_o("sat_stall", 1'b0, 1'b0, 1'b1);
        next_cyc(); wb_gpr(5'd7); settle(); chk_o("sat_wb_cycle", 1'b0, 1'b0, 1'b1);
        next_cyc(); wb_off(); settle(); chk_o("sat_unblock", 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            next_cyc(); clr(); wb_gpr(5'd7); settle();
            chk_idle($sformatf("sat_rel%0d", k), 1'b0);
        end
        next_cyc(); clr(); settle(); chk_idle("sat_done", 1'b1);

        // Flush during stall
        next_cyc(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1); settle();
        chk_o("fl_alloc", 1'b1, 1'b1, 1'b0);
        next_cyc(); instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
        sb_if.flush = 1'b1; sb_if.EXU_ready = 1'b0; settle();
        chk_o("fl_flush", 1'b0, 1'b1, 1'b0);
        next_cyc(); sb_if.flush = 1'b0; sb_if.EXU_ready = 1'b1; settle();
        chk_o("fl_still", 1'b0, 1'b0, 1'b1);
        next_cyc(); instr(5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0); settle();
        chk_o("fl_no_alloc8", 1'b1, 1'b1, 1'b0);
        next_cyc(); clr(); wb_gpr(5'd5); settle(); chk_idle("fl_rel5", 1'b0);
        next_cyc(); clr(); settle(); chk_idle("fl_done", 1'b1);

        // Simultaneous allocate and release of x9
        next_cyc(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); settle();
        chk_o("x9_first", 1'b1, 1'b1, 1'b0);
        next_cyc(); instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); wb_gpr(5'd9); settle();
        chk_o("x9_same", 1'b1, 1'b1, 1'b0);
        next_cyc(); clr(); instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
        chk_o("x9_held", 1'b0, 1'b0, 1'b1); chk_idle("x9_held", 1'b0);
        next_cyc(); clr(); wb_gpr(5'd9); settle();
        next_cyc(); clr(); settle(); chk_idle("x9_infl_one", 1'b1);

        // CSR hazard cleared by reset
        next_cyc(); clr(); sb_if.IDU_valid = 1'b1; sb_if.IDU_write_csr = 1'b1;
        sb_if.IDU_csr_rd = 3'd2; settle();
        chk_o("csr_issue", 1'b1, 1'b1, 1'b0);
        next_cyc(); clr(); sb_if.IDU_valid = 1'b1; sb_if.IDU_use_csr = 1'b1;
        sb_if.IDU_csr_rs = 3'd2; settle();
        chk_o("csr_stall", 1'b0, 1'b0, 1'b1); chk_idle("csr_stall", 1'b0);
        next_cyc(); rst = 1'b1; settle();
        next_cyc(); rst = 1'b0; settle();
        chk_o("csr_after_rst", 1'b1, 1'b1, 1'b0); chk_idle("csr_after_rst", 1'b1);
        next_cyc(); clr(); settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
